// File: rtl/digseg_scan.sv
// digseg_scan
// Bus-side initiator for the seven-segment digit driver. Holds a display
// value and a control word written over a simple strobe/ack peripheral bus,
// and scans the value one nibble at a time through an external digit driver
// (req/ack handshake). The segment pattern returned by the driver is latched
// and shown on the board for a fixed dwell time per digit.
//
// Ports:
//   clk, rst             system clock, asynchronous active-high reset
//   stb_i, we_i, addr_i  bus strobe, write enable, register select (0 VALUE, 1 CTRL)
//   data_i, data_o       bus write data, bus read data (valid while ack_o high)
//   ack_o                one-cycle bus acknowledge
//   nib_o, req_o         nibble and request towards the digit driver
//   nib_ack_i, seg_i     driver acknowledge and active-high segment pattern (bit 6 = a)
//   an_o                 active-low digit anodes, at most one low
//   seg_o                active-low segment pins
module digseg_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic              addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              ack_o,
  output logic [3:0]        nib_o,
  output logic              req_o,
  input  logic              nib_ack_i,
  input  logic [6:0]        seg_i,
  output logic [DIGITS-1:0] an_o,
  output logic [6:0]        seg_o
);

  localparam int VW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {FETCH, HOLD, DEAD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        nib_q, nib_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic              req_q, req_d;
  logic [VW-1:0]     value_q, value_d;
  logic [DIGITS:0]   ctrl_q, ctrl_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              accept;
  logic              data_unused;

  // Upper data bits beyond the register widths are ignored on write.
  assign data_unused = ^data_i;

  // Bus side: an access is taken whenever the strobe is up and no ack is
  // pending, so a held strobe naturally yields one ack every other cycle.
  always_comb begin
    accept  = stb_i && !ack_q;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    ack_d   = accept;
    rdata_d = '0;
    if (accept) begin
      if (we_i) begin
        if (addr_i) ctrl_d = data_i[DIGITS:0];
        else        value_d = data_i[VW-1:0];
      end else begin
        rdata_d = addr_i ? 32'(ctrl_q) : 32'(value_q);
      end
    end
  end

  // Scan sequencing. The digit index is advanced on the way into DEAD, which
  // keeps the reset DEAD state (idx 0) from skipping digit 0. The nibble is
  // sampled from the pre-write VALUE on entry to FETCH and then held.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    nib_d   = nib_q;
    seg_d   = seg_q;
    unique case (state_q)
      FETCH: begin
        if (nib_ack_i) begin
          seg_d   = ~seg_i;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DEAD;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEAD: begin
        state_d = FETCH;
        nib_d   = value_q[{idx_q, 2'b00} +: 4];
      end
      default: state_d = DEAD;
    endcase
  end

  // Registered pin outputs are computed from next-state values; using the
  // next CTRL lets a CTRL write show on the anodes the cycle after it lands.
  always_comb begin
    req_d = (state_d == FETCH);
    an_d  = '1;
    if (state_d == HOLD && ctrl_d[idx_q] && !ctrl_d[DIGITS]) an_d[idx_q] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DEAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      nib_q   <= '0;
      seg_q   <= '1;
      an_q    <= '1;
      req_q   <= 1'b0;
      value_q <= '0;
      ctrl_q  <= {1'b0, {DIGITS{1'b1}}};
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      req_q   <= req_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_o = rdata_q;
  assign ack_o  = ack_q;
  assign nib_o  = nib_q;
  assign req_o  = req_q;
  assign an_o   = an_q;
  assign seg_o  = seg_q;

endmodule

// File: tb/tb_digseg_scan.sv
// tb_digseg_scan
// Self-checking bench for digseg_scan with DIGITS=8, SCAN_DIV=4. The bench
// plays the external digit driver (hex decoder on nib_o), drives the bus,
// and compares every cycle against a slot-timeline reference model. Bus
// accesses are queued with their expected read data and retired by the
// monitor when ack_o is seen.
module tb_digseg_scan;

  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;

  logic        clk, rst, stb_i, we_i, addr_i, nib_ack_i, ack_o, req_o;
  logic [31:0] data_i, data_o;
  logic [3:0]  nib_o;
  logic [6:0]  seg_i, seg_o;
  logic [DIGITS-1:0] an_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic        addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
  } bus_item_t;

  bus_item_t sbq[$];
  bus_item_t mon_it;

  // Bench-side view of the registers, used for expected read data.
  logic [31:0] sh_value;
  logic [8:0]  sh_ctrl;

  // Reference model of the display, advanced once per clock edge.
  logic [31:0] m_value;
  logic [8:0]  m_ctrl;
  int          m_idx, m_hold;
  bit          m_fetch, m_gap, m_started, prev_nack;
  logic [3:0]  m_nib;
  logic [6:0]  m_seg;
  logic [7:0]  exp_an;

  digseg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .stb_i(stb_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .nib_o(nib_o),
    .req_o(req_o), .nib_ack_i(nib_ack_i), .seg_i(seg_i), .an_o(an_o),
    .seg_o(seg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-high hex decoder, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] hexseg(input logic [3:0] n);
    case (n)
      4'h0: hexseg = 7'h7E; 4'h1: hexseg = 7'h30; 4'h2: hexseg = 7'h6D; 4'h3: hexseg = 7'h79;
      4'h4: hexseg = 7'h33; 4'h5: hexseg = 7'h5B; 4'h6: hexseg = 7'h5F; 4'h7: hexseg = 7'h70;
      4'h8: hexseg = 7'h7F; 4'h9: hexseg = 7'h7B; 4'hA: hexseg = 7'h77; 4'hB: hexseg = 7'h1F;
      4'hC: hexseg = 7'h4E; 4'hD: hexseg = 7'h3D; 4'hE: hexseg = 7'h4F; default: hexseg = 7'h47;
    endcase
  endfunction

  assign seg_i = hexseg(nib_o);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus access; the expected response is queued before the strobe goes up.
  task automatic applyStimulus(input logic we, input logic addr, input logic [31:0] data);
    bus_item_t it;
    @(posedge clk); #2;
    it.we = we; it.addr = addr; it.data = data;
    it.exp_rd = addr ? {23'b0, sh_ctrl} : sh_value;
    if (we) begin
      if (addr) sh_ctrl = data[8:0];
      else      sh_value = data;
    end
    sbq.push_back(it);
    stb_i = 1'b1; we_i = we; addr_i = addr; data_i = data;
    @(posedge clk); #2;
    stb_i = 1'b0; we_i = 1'b0; data_i = '0;
    @(posedge clk);
  endtask

  // Strobe held for 2n cycles must produce exactly n reads.
  task automatic burstRead(input logic addr, input int n);
    bus_item_t it;
    @(posedge clk); #2;
    for (int k = 0; k < n; k++) begin
      it.we = 1'b0; it.addr = addr; it.data = '0;
      it.exp_rd = addr ? {23'b0, sh_ctrl} : sh_value;
      sbq.push_back(it);
    end
    stb_i = 1'b1; we_i = 1'b0; addr_i = addr;
    repeat (2 * n) @(posedge clk);
    #2 stb_i = 1'b0;
    @(posedge clk);
  endtask

  // Monitor: advance the slot timeline, retire bus acks, compare all outputs.
  always begin : monitor
    @(negedge clk);
    if (rst) begin
      m_value = '0; m_ctrl = 9'h0FF; m_idx = DIGITS - 1; m_hold = 0;
      m_fetch = 0; m_gap = 1; m_nib = '0; m_seg = 7'h7F; m_started = 0;
      checkOutput("rst_an", an_o, 8'hFF);
      checkOutput("rst_seg", seg_o, 7'h7F);
      checkOutput("rst_req", req_o, 0);
      checkOutput("rst_nib", nib_o, 0);
      checkOutput("rst_ack", ack_o, 0);
      checkOutput("rst_data", data_o, 0);
    end else begin
      if (m_started) begin
        if (m_fetch) begin
          if (prev_nack) begin
            m_fetch = 0;
            m_hold  = SCAN_DIV;
            m_seg   = ~hexseg(m_nib);
          end
        end else if (m_hold > 0) begin
          m_hold--;
          if (m_hold == 0) m_gap = 1;
        end else if (m_gap) begin
          m_gap   = 0;
          m_fetch = 1;
          m_idx   = (m_idx + 1) % DIGITS;
          m_nib   = m_value[4*m_idx +: 4];
        end
      end
      m_started = 1;
      if (ack_o) begin
        if (sbq.size() == 0) begin
          checkOutput("ack_unexpected", ack_o, 0);
        end else begin
          mon_it = sbq.pop_front();
          checkOutput("bus_rdata", data_o, mon_it.we ? 32'h0 : mon_it.exp_rd);
          if (mon_it.we) begin
            if (mon_it.addr) m_ctrl = mon_it.data[8:0];
            else             m_value = mon_it.data;
          end
        end
      end else begin
        checkOutput("data_idle", data_o, 0);
      end
      exp_an = 8'hFF;
      if (m_hold > 0 && m_ctrl[m_idx] && !m_ctrl[8]) exp_an[m_idx] = 1'b0;
      checkOutput("scan_req", req_o, m_fetch);
      checkOutput("scan_an", an_o, exp_an);
      checkOutput("scan_seg", seg_o, m_seg);
      checkOutput("scan_nib", nib_o, m_nib);
    end
    prev_nack = nib_ack_i;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    bit found;
    int r;
    rst = 1'b1; stb_i = 1'b0; we_i = 1'b0; addr_i = 1'b0; data_i = '0; nib_ack_i = 1'b1;
    sh_value = '0; sh_ctrl = 9'h0FF;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Two frames of free-running scan over VALUE=0.
    repeat (2 * DIGITS * (SCAN_DIV + 2)) @(posedge clk);

    applyStimulus(1'b1, 1'b0, 32'h89ABCDEF);
    applyStimulus(1'b0, 1'b0, 32'h0);
    repeat (DIGITS * (SCAN_DIV + 2)) @(posedge clk);

    // Masked digits, then global blank, then upper CTRL bits ignored.
    applyStimulus(1'b1, 1'b1, 32'h0F5);
    applyStimulus(1'b0, 1'b1, 32'h0);
    repeat (DIGITS * (SCAN_DIV + 2)) @(posedge clk);
    applyStimulus(1'b1, 1'b1, 32'h1FF);
    repeat (DIGITS * (SCAN_DIV + 2)) @(posedge clk);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FEFF);
    applyStimulus(1'b0, 1'b1, 32'h0);

    // Driver stall long enough to hold one FETCH for 20+ cycles.
    @(posedge clk); #2 nib_ack_i = 1'b0;
    repeat (28) @(posedge clk);
    #2 nib_ack_i = 1'b1;
    repeat (12) @(posedge clk);

    burstRead(1'b0, 3);

    // VALUE rewritten while digit 2 is being shown.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (an_o == 8'hFB) found = 1;
    end
    checkOutput("digit2_seen", found, 1);
    applyStimulus(1'b1, 1'b0, 32'h0123_4567);
    repeat (2 * DIGITS * (SCAN_DIV + 2)) @(posedge clk);

    // Random bus traffic and driver stalls.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: applyStimulus(1'b1, 1'b0, $urandom);
        1: applyStimulus(1'b1, 1'b1, $urandom);
        2: applyStimulus(1'b0, 1'b0, 32'h0);
        default: applyStimulus(1'b0, 1'b1, 32'h0);
      endcase
      #2 nib_ack_i = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 7)) @(posedge clk);
    end
    @(posedge clk); #2 nib_ack_i = 1'b1;
    applyStimulus(1'b1, 1'b1, 32'h0FF);
    repeat (20) @(posedge clk);

    // Reset asserted in the middle of a dwell must clear pins immediately.
    found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (an_o != 8'hFF) found = 1;
    end
    checkOutput("hold_seen", found, 1);
    #1 rst = 1'b1;
    #1;
    checkOutput("async_an", an_o, 8'hFF);
    checkOutput("async_seg", seg_o, 7'h7F);
    checkOutput("async_req", req_o, 0);
    sbq.delete();
    sh_value = '0; sh_ctrl = 9'h0FF;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (DIGITS * (SCAN_DIV + 2) + 4) @(posedge clk);

    checkOutput("queue_empty", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
